alu_top: RTL and testbench

Switch-driven 32-bit ALU wrapper for the board-level lab design. Three switches load operand A, operand B and a 3-bit opcode from a shared 32-bit input bus into internal registers. A combinational 8-function ALU computes result F and flags. Two display switches select whether F or the flag word drives the registered 32-bit output bus.

---
 rtl/alu_top.sv | 95 +++++++++
 tb/tb_alu_top.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_top.sv
// Switch-driven ALU wrapper: operand and opcode registers loaded from a shared bus,
// a combinational 8-function ALU, and a registered display bus selecting F or flags.
module alu_top #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       SW,
    input  logic [WIDTH:1]   Input_Data,
    output logic [WIDTH:1]   Output_Data
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_XOR = 3'd2,
        OP_NOR = 3'd3,
        OP_ADD = 3'd4,
        OP_SUB = 3'd5,
        OP_SLT = 3'd6,
        OP_SHL = 3'd7
    } opcode_e;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    opcode_e          op;

    logic [WIDTH-1:0] b_in;
    logic             carry_in;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] f;
    logic             zf;
    logic             cf;
    logic             of;
    logic [WIDTH-1:0] flag_word;
    logic             unused_sw;

    assign unused_sw = SW[0];

    // ADD and SUB share one adder; SUB feeds ~B with a carry-in of one.
    always_comb begin
        b_in     = (op == OP_SUB) ? ~b : b;
        carry_in = (op == OP_SUB);
        {carry, sum} = {1'b0, a} + {1'b0, b_in} + {{WIDTH{1'b0}}, carry_in};
    end

    always_comb begin
        f  = '0;
        cf = 1'b0;
        of = 1'b0;
        case (op)
            OP_AND: f = a & b;
            OP_OR:  f = a | b;
            OP_XOR: f = a ^ b;
            OP_NOR: f = ~(a | b);
            OP_ADD: begin
                f  = sum;
                cf = carry;
                of = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                f  = sum;
                cf = ~carry;
                of = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: f = ($signed(a) < $signed(b)) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
            OP_SHL: f = b << a[SHW-1:0];
            default: f = '0;
        endcase
        zf        = (f == '0);
        flag_word = {{(WIDTH-3){1'b0}}, of, cf, zf};
    end

    // The display register samples F/flags from the pre-load register values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a           <= '0;
            b           <= '0;
            op          <= OP_AND;
            Output_Data <= '0;
        end else begin
            if (SW[1]) a  <= Input_Data;
            if (SW[2]) b  <= Input_Data;
            if (SW[3]) op <= opcode_e'(Input_Data[3:1]);
            if (SW[5])
                Output_Data <= flag_word;
            else if (SW[4])
                Output_Data <= f;
        end
    end

endmodule

// File: tb/tb_alu_top.sv
// Self-checking bench for alu_top: directed cases from the lab sheet followed by
// random switch/bus traffic checked against an arithmetic reference model.
module tb_alu_top;

    logic        clk;
    logic        rst_n;
    logic [5:0]  SW;
    logic [32:1] Input_Data;
    logic [32:1] Output_Data;

    int n_checks;
    int n_fail;

    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [2:0]  m_op;
    logic [31:0] m_out;

    alu_top #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .SW          (SW),
        .Input_Data  (Input_Data),
        .Output_Data (Output_Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] modelF(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a | b);
            3'd4: return a + b;
            3'd5: return a - b;
            3'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return b << (a % 32);
        endcase
    endfunction

    function automatic logic [31:0] modelFlags(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        longint sa, sb, ua, ub, r;
        logic zf, cf, of;
        longint lo, hi;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        lo = -(longint'(1) <<< 31);
        hi = (longint'(1) <<< 31) - 1;
        zf = (modelF(a, b, op) == 32'd0);
        cf = 1'b0;
        of = 1'b0;
        if (op == 3'd4) begin
            cf = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
            r  = sa + sb;
            of = (r < lo) || (r > hi);
        end else if (op == 3'd5) begin
            cf = (ua < ub);
            r  = sa - sb;
            of = (r < lo) || (r > hi);
        end
        return {29'd0, of, cf, zf};
    endfunction

    task automatic applyStimulus(input logic [5:0] sw, input logic [31:0] data);
        @(negedge clk);
        SW         = sw;
        Input_Data = data;
        @(posedge clk);
        if (!rst_n) begin
            m_a = 0; m_b = 0; m_op = 0; m_out = 0;
        end else begin
            if (sw[5])      m_out = modelFlags(m_a, m_b, m_op);
            else if (sw[4]) m_out = modelF(m_a, m_b, m_op);
            if (sw[1]) m_a  = data;
            if (sw[2]) m_b  = data;
            if (sw[3]) m_op = data[2:0];
        end
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] expected);
        n_checks++;
        assert (Output_Data === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: got %h expected %h", tag, Output_Data, expected);
        end
    endtask

    task automatic doReset(input logic [5:0] sw);
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(sw, 32'hFFFF_FFFF);
        rst_n = 1'b1;
    endtask

    task automatic loadRegs(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        applyStimulus(6'b000010, a);
        applyStimulus(6'b000100, b);
        applyStimulus(6'b001000, {29'd0, op});
    endtask

    task automatic showF(input string tag, input logic [31:0] expected);
        applyStimulus(6'b010000, $urandom);
        checkOutput(tag, expected);
    endtask

    task automatic showFlags(input string tag, input logic [31:0] expected);
        applyStimulus(6'b100000, $urandom);
        checkOutput(tag, expected);
    endtask

    initial begin
        logic [5:0]  sw;
        logic [31:0] data;
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b1;
        SW         = 6'd0;
        Input_Data = 32'd0;
        m_a = 0; m_b = 0; m_op = 0; m_out = 0;

        // Switches held high during reset must not win over it.
        doReset(6'b111110);
        checkOutput("reset_out", 32'h0);
        showF("reset_F", 32'h0);
        showFlags("reset_flags", 32'h1);

        loadRegs(32'h0001FFFF, 32'h0001000F, 3'd0);
        showF("and_F", 32'h0001000F);
        showFlags("and_flags", 32'h0);
        applyStimulus(6'b001000, 32'd1);
        showF("or_F", 32'h0001FFFF);
        showFlags("or_flags", 32'h0);
        applyStimulus(6'b001000, 32'd2);
        showF("xor_F", 32'h0000FFF0);
        showFlags("xor_flags", 32'h0);
        applyStimulus(6'b001000, 32'd3);
        showF("nor_F", 32'hFFFE0000);
        showFlags("nor_flags", 32'h0);

        loadRegs(32'hFFF1FFFF, 32'h0001000F, 3'd4);
        showF("add_F", 32'hFFF3000E);
        showFlags("add_flags", 32'h0);
        loadRegs(32'hFFFFFFFF, 32'h00000001, 3'd4);
        showF("add_carry_F", 32'h0);
        showFlags("add_carry_flags", 32'h3);
        loadRegs(32'h7FFFFFFF, 32'h00000001, 3'd4);
        showF("add_ovf_F", 32'h80000000);
        showFlags("add_ovf_flags", 32'h4);

        loadRegs(32'h0001FFFF, 32'hFFF1000F, 3'd5);
        showF("sub_F", 32'h0010FFF0);
        showFlags("sub_flags", 32'h2);
        loadRegs(32'd5, 32'd5, 3'd5);
        showF("sub_eq_F", 32'h0);
        showFlags("sub_eq_flags", 32'h1);

        loadRegs(32'h0001FFFF, 32'h0001000F, 3'd6);
        showF("slt_F", 32'h0);
        showFlags("slt_flags", 32'h1);
        loadRegs(32'hFFFFFFFF, 32'h00000001, 3'd6);
        showF("slt_neg_F", 32'h1);

        loadRegs(32'd4, 32'hFFFFFFFF, 3'd7);
        showF("shl_F", 32'hFFFFFFF0);
        applyStimulus(6'b000010, 32'h24);
        showF("shl_mask_F", 32'hFFFFFFF0);
        loadRegs(32'd31, 32'd1, 3'd7);
        showF("shl_31_F", 32'h80000000);

        // Load and display in the same cycle shows the pre-load result.
        applyStimulus(6'b010010, 32'd4);
        checkOutput("load_show_same", 32'h80000000);
        showF("load_show_after", 32'h00000010);

        doReset(6'b000000);
        showF("midreset_F", 32'h0);
        showFlags("midreset_flags", 32'h1);
        loadRegs(32'd3, 32'd7, 3'd1);
        applyStimulus(6'b110000, 32'd0);
        checkOutput("both_display", 32'h0);
        applyStimulus(6'b000000, 32'hDEADBEEF);
        checkOutput("hold_1", 32'h0);
        showF("or_after_reset", 32'h7);
        applyStimulus(6'b000001, 32'h12345678);
        checkOutput("hold_2", 32'h7);

        for (int i = 0; i < 400; i++) begin
            sw = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 3))
                0:       data = $urandom_range(0, 7);
                1:       data = {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'h7FFFFFFF};
                default: data = $urandom;
            endcase
            applyStimulus(sw, data);
            checkOutput("random", m_out);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
